// File: rtl/mat_config_arbiter.sv
// mat_config_arbiter: round-robin serializer of table-write requests onto the config_mat update port.
// Define MAT_CFG_STATS_EN to build the 32-bit stat_write_count register; otherwise it is tied to 0.
`ifndef MATCH_KEY_WIDTH
`define MATCH_KEY_WIDTH 32
`endif
`ifndef MAT_ADDR_WIDTH
`define MAT_ADDR_WIDTH 8
`endif

module mat_config_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int KEY_WIDTH   = `MATCH_KEY_WIDTH,
    parameter int VALUE_WIDTH = 128,
    parameter int ADDR_WIDTH  = `MAT_ADDR_WIDTH,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             s_req_valid,
    output logic [NUM_REQ-1:0]             s_req_ready,
    input  logic [NUM_REQ*KEY_WIDTH-1:0]   s_req_key,
    input  logic [NUM_REQ*VALUE_WIDTH-1:0] s_req_value,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  s_req_addr,
    output logic                           config_mat_en,
    output logic [KEY_WIDTH-1:0]           config_mat_key,
    output logic [VALUE_WIDTH-1:0]         config_mat_value,
    output logic [ADDR_WIDTH-1:0]          config_mat_addr,
    output logic                           busy,
    output logic [31:0]                    stat_write_count
);
    localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] last_grant, grant_idx, cand;
    logic             grant_found, handshake;
    logic [7:0]       gap_cnt;

    // Search starts one past last_grant and wraps, giving a strictly rotating order.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = last_grant;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
            if (!grant_found && s_req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign handshake = (state == IDLE) && grant_found && !rst;

    always_comb begin
        s_req_ready = '0;
        if (handshake) s_req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_found) state_next = WRITE;
            WRITE:   state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_cnt == 8'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant       <= LAST_IDX;
            gap_cnt          <= '0;
            config_mat_key   <= '0;
            config_mat_value <= '0;
            config_mat_addr  <= '0;
        end else begin
            if (handshake) begin
                last_grant       <= grant_idx;
                config_mat_key   <= s_req_key[grant_idx*KEY_WIDTH +: KEY_WIDTH];
                config_mat_value <= s_req_value[grant_idx*VALUE_WIDTH +: VALUE_WIDTH];
                config_mat_addr  <= s_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
            if (state == WRITE)                         gap_cnt <= GAP_LOAD;
            else if (state == GAP && gap_cnt != 8'd0)   gap_cnt <= gap_cnt - 8'd1;
        end
    end

    // The strobe is a decode of the state register, so reset kills a pending pulse at once.
    assign config_mat_en = (state == WRITE);
    assign busy          = (state != IDLE);

`ifdef MAT_CFG_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                stat_write_count <= '0;
        else if (config_mat_en) stat_write_count <= stat_write_count + 32'd1;
    end
`else
    assign stat_write_count = '0;
`endif

endmodule

// File: tb/tb_mat_config_arbiter.sv
// tb_mat_config_arbiter: scoreboard bench driving GAP_CYCLES=2 and GAP_CYCLES=0 instances with shared stimulus.
module tb_mat_config_arbiter;
    localparam int N = 4, KW = 32, VW = 128, AW = 8;
    localparam int GAP_A = 2, GAP_B = 0;
`ifdef MAT_CFG_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [KW-1:0] key;
        logic [VW-1:0] value;
        logic [AW-1:0] addr;
    } pay_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    valid = '0;
    logic [N*KW-1:0] key_bus;
    logic [N*VW-1:0] value_bus;
    logic [N*AW-1:0] addr_bus;

    logic [N-1:0]  rdy_a, rdy_b;
    logic          en_a, en_b, busy_a, busy_b;
    logic [KW-1:0] key_a, key_b;
    logic [VW-1:0] val_a, val_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [31:0]   stat_a, stat_b;

    always #5 clk = ~clk;

    mat_config_arbiter #(.NUM_REQ(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .ADDR_WIDTH(AW),
                         .GAP_CYCLES(GAP_A)) dut_a (
        .clk(clk), .rst(rst), .s_req_valid(valid), .s_req_ready(rdy_a),
        .s_req_key(key_bus), .s_req_value(value_bus), .s_req_addr(addr_bus),
        .config_mat_en(en_a), .config_mat_key(key_a), .config_mat_value(val_a),
        .config_mat_addr(addr_a), .busy(busy_a), .stat_write_count(stat_a));

    mat_config_arbiter #(.NUM_REQ(N), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .ADDR_WIDTH(AW),
                         .GAP_CYCLES(GAP_B)) dut_b (
        .clk(clk), .rst(rst), .s_req_valid(valid), .s_req_ready(rdy_b),
        .s_req_key(key_bus), .s_req_value(value_bus), .s_req_addr(addr_bus),
        .config_mat_en(en_b), .config_mat_key(key_b), .config_mat_value(val_b),
        .config_mat_addr(addr_b), .busy(busy_b), .stat_write_count(stat_b));

    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pay_t pay_of(input int i);
        pay_t p;
        p.key   = (i == 2) ? 32'h0000_1234 : 32'h1000_0000 | 32'(i);
        p.value = (i == 2) ? {16{8'hAA}} : {4{32'hC0DE_0000 | 32'(i)}};
        p.addr  = (i == 2) ? 8'd5 : 8'h10 + 8'(i);
        return p;
    endfunction

    // Cycle-level reference: remaining busy cycles, pending pulse and rotating pointer per instance.
    int   m_last[2], m_left[2], m_writes[2], busy_cnt[2], cyc;
    bit   m_pulse[2];
    pay_t q_a[$], q_b[$];
    int   glog_a[$], glog_b[$], pcyc_a[$];
    logic [KW-1:0] pkey_b[$];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_last[d] = N - 1; m_left[d] = 0; m_pulse[d] = 1'b0; m_writes[d] = 0;
        end
        q_a.delete(); q_b.delete();
    endtask

    task automatic clear_logs();
        glog_a.delete(); glog_b.delete(); pcyc_a.delete(); pkey_b.delete();
        busy_cnt[0] = 0; busy_cnt[1] = 0; cyc = 0;
    endtask

    task automatic model_step(input int d);
        logic [N-1:0] o_rdy, exp_rdy;
        logic         o_en, o_busy;
        logic [31:0]  o_stat;
        pay_t         o_pay, exp_pay;
        int           win, idx, gap;
        if (d == 0) begin
            o_rdy = rdy_a; o_en = en_a; o_busy = busy_a; o_stat = stat_a; gap = GAP_A;
            o_pay.key = key_a; o_pay.value = val_a; o_pay.addr = addr_a;
        end else begin
            o_rdy = rdy_b; o_en = en_b; o_busy = busy_b; o_stat = stat_b; gap = GAP_B;
            o_pay.key = key_b; o_pay.value = val_b; o_pay.addr = addr_b;
        end
        win = -1;
        exp_rdy = '0;
        if (m_left[d] == 0) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last[d] + k) % N;
                if (win < 0 && ((valid >> idx) & 4'b0001) != 4'b0000) win = idx;
            end
        end
        if (win >= 0) exp_rdy = 4'b0001 << win;
        check($sformatf("ready%0d", d), o_rdy, exp_rdy);
        check($sformatf("en%0d", d), o_en, m_pulse[d]);
        check($sformatf("busy%0d", d), o_busy, m_left[d] > 0);
        check($sformatf("stat%0d", d), o_stat, STATS ? m_writes[d] : 0);
        if (o_busy) busy_cnt[d]++;
        for (int i = 0; i < N; i++) begin
            if (((o_rdy >> i) & 4'b0001) != 4'b0000) begin
                if (d == 0) glog_a.push_back(i);
                else        glog_b.push_back(i);
            end
        end
        if (o_en) begin
            if (d == 0) pcyc_a.push_back(cyc);
            else        pkey_b.push_back(o_pay.key);
        end
        if (m_pulse[d]) begin
            if (d == 0 && q_a.size() == 0)      check("sb_underflow0", q_a.size(), 1);
            else if (d == 1 && q_b.size() == 0) check("sb_underflow1", q_b.size(), 1);
            else begin
                if (d == 0) exp_pay = q_a.pop_front();
                else        exp_pay = q_b.pop_front();
                check($sformatf("payload%0d", d), o_pay, exp_pay);
            end
        end
        if (win >= 0) begin
            if (d == 0) q_a.push_back(pay_of(win));
            else        q_b.push_back(pay_of(win));
        end
        if (m_pulse[d]) m_writes[d]++;
        m_pulse[d] = (win >= 0);
        if (win >= 0) begin
            m_left[d] = 1 + gap;
            m_last[d] = win;
        end else if (m_left[d] > 0) begin
            m_left[d]--;
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic cycle();
        #1;
        model_step(0);
        model_step(1);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid = '1;
        #1;
        check("rst_ready_a", rdy_a, 0);
        check("rst_ready_b", rdy_b, 0);
        check("rst_en_a", en_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_stat_a", stat_a, 0);
        check("rst_key_a", key_a, 0);
        check("rst_addr_b", addr_b, 0);
        @(negedge clk);
        @(negedge clk);
        valid = '0;
        rst = 1'b0;
        model_reset();
        clear_logs();
    endtask

    int order2[5] = '{0, 1, 2, 3, 0};
    int order3[3] = '{1, 3, 1};

    initial begin
        for (int i = 0; i < N; i++) begin
            pay_t p;
            p = pay_of(i);
            key_bus[i*KW +: KW]   = p.key;
            value_bus[i*VW +: VW] = p.value;
            addr_bus[i*AW +: AW]  = p.addr;
        end
        model_reset();
        clear_logs();
        @(negedge clk);
        do_reset();

        // Single request from requester 2.
        valid = 4'b0100; cycle();
        valid = '0; repeat (5) cycle();
        check("p1_grants_a", glog_a.size(), 1);
        if (glog_a.size() > 0) check("p1_winner_a", glog_a[0], 2);
        check("p1_pulses_a", pcyc_a.size(), 1);
        if (pcyc_a.size() > 0) check("p1_latency_a", pcyc_a[0], 1);
        check("p1_busy_a", busy_cnt[0], 3);
        check("p1_busy_b", busy_cnt[1], 1);

        // All requesters valid from reset.
        do_reset();
        valid = '1; repeat (18) cycle();
        valid = '0; repeat (5) cycle();
        check("p2_grants_a", glog_a.size(), 5);
        for (int i = 0; i < 5 && i < glog_a.size(); i++) check("p2_order_a", glog_a[i], order2[i]);
        for (int i = 1; i < pcyc_a.size(); i++) check("p2_spacing_a", pcyc_a[i] - pcyc_a[i-1], 4);

        // Back-to-back with requesters 1 and 3 on the zero-gap instance.
        do_reset();
        valid = 4'b1010; repeat (6) cycle();
        valid = '0; repeat (4) cycle();
        check("p3_pulses_b", pkey_b.size(), 3);
        for (int i = 0; i < 3 && i < pkey_b.size(); i++) begin
            pay_t p;
            p = pay_of(order3[i]);
            check("p3_key_b", pkey_b[i], p.key);
        end

        // Requester 0 raises valid during the gap and withdraws before idle.
        clear_logs();
        valid = 4'b0100; cycle();
        valid = '0;      cycle();
        valid = 4'b0001; repeat (2) cycle();
        valid = '0;      repeat (4) cycle();
        check("p4_grants_a", glog_a.size(), 1);
        if (glog_a.size() > 0) check("p4_winner_a", glog_a[0], 2);
        check("p4_pulses_a", pcyc_a.size(), 1);

        // Asynchronous reset landing in the write cycle.
        valid = 4'b0010; cycle();
        valid = '0;
        #1 check("p5_en_before", en_a, 1);
        #1 rst = 1'b1;
        #1;
        check("p5_en_a", en_a, 0);
        check("p5_en_b", en_b, 0);
        check("p5_busy_a", busy_a, 0);
        check("p5_stat_a", stat_a, 0);
        check("p5_stat_b", stat_b, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_logs();
        valid = '1; cycle();
        valid = '0; repeat (4) cycle();
        check("p5_first_a", (glog_a.size() > 0) ? glog_a[0] : -1, 0);
        check("p5_first_b", (glog_b.size() > 0) ? glog_b[0] : -1, 0);

        // Ten accepted writes on the gapped instance.
        do_reset();
        valid = '1;
        for (int t = 0; t < 100 && glog_a.size() < 10; t++) cycle();
        valid = '0; repeat (6) cycle();
        check("p6_grants_a", glog_a.size(), 10);
        check("p6_stat_a", stat_a, STATS ? 10 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
